// File: rtl/pio_edge_capture.sv
// rtl/pio_edge_capture.sv - Avalon-MM GPIO with synchronised inputs, edge capture, IRQ and output register.
// Optional macro PIO_BITSET_EN adds outset (address 4) and outclear (address 5) writes.
module pio_edge_capture #(
  parameter int unsigned           WIDTH       = 16,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter int unsigned           EDGE_TYPE   = 0,
  parameter int unsigned           IRQ_TYPE    = 0,
  parameter logic [WIDTH-1:0]      RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [31:0]      rd_q, rd_d;
  logic             irq_q, irq_d;
  logic [2:0]       prime_q, prime_d;

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise, fall, edge_hit;
  logic             wr;
  logic             unused_wdata;

  assign sync_in      = sync_q[SYNC_STAGES-1];
  assign wdata        = writedata[WIDTH-1:0];
  assign wr           = chipselect & ~write_n;
  assign rise         = sync_in & ~prev_q;
  assign fall         = ~sync_in & prev_q;
  assign unused_wdata = ^writedata;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d  = sync_in;
    prime_d = (prime_q == PRIME_MAX) ? prime_q : prime_q + 3'd1;
  end

  // Until the chain and prev have settled after reset, any apparent edge is stale.
  always_comb begin
    edge_hit = '0;
    if (prime_q == PRIME_MAX) begin
      case (EDGE_TYPE)
        0:       edge_hit = rise;
        1:       edge_hit = fall;
        default: edge_hit = rise | fall;
      endcase
    end
  end

  always_comb begin
    mask_d = mask_q;
    out_d  = out_q;
    cap_d  = cap_q;
    if (wr && address == 3'd0) out_d  = wdata;
    if (wr && address == 3'd2) mask_d = wdata;
    if (wr && address == 3'd3) cap_d  = cap_q & ~wdata;
`ifdef PIO_BITSET_EN
    if (wr && address == 3'd4) out_d = out_q | wdata;
    if (wr && address == 3'd5) out_d = out_q & ~wdata;
`endif
    // A fresh edge overrides a same-cycle clear.
    cap_d = cap_d | edge_hit;
  end

  always_comb begin
    rd_d = '0;
    case (address)
      3'd0:    rd_d[WIDTH-1:0] = sync_in;
      3'd1:    rd_d[WIDTH-1:0] = out_q;
      3'd2:    rd_d[WIDTH-1:0] = mask_q;
      3'd3:    rd_d[WIDTH-1:0] = cap_q;
      default: rd_d = '0;
    endcase
    irq_d = (IRQ_TYPE == 0) ? |(sync_in & mask_q) : |(cap_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      out_q   <= RESET_OUT;
      rd_q    <= '0;
      irq_q   <= 1'b0;
      prime_q <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
      rd_q    <= rd_d;
      irq_q   <= irq_d;
      prime_q <= prime_d;
    end
  end

  assign readdata = rd_q;
  assign out_port = out_q;
  assign irq      = irq_q;

endmodule

// File: doc/pio_edge_capture.md
Name: pio_edge_capture

Overview:
- Parametrised successor to the team's 16-bit input-only PIO: Avalon-MM slave with WIDTH-bit input and output ports.
- Adds:
  - input synchronisers;
  - per-bit edge detection, with a sticky edge-capture register cleared by writing 1;
  - level or edge interrupt mode;
  - an output data register.
- Sits on the Qsys/Nios II interconnect as a GPIO/interrupt source peripheral.

Parameters:
- WIDTH, 16, port width in bits; legal range 1..32.
- SYNC_STAGES, 2, synchroniser flops on in_port; legal range 2..4.
- EDGE_TYPE, 0, edge to capture: 0 rising, 1 falling, 2 any.
- IRQ_TYPE, 0, interrupt source: 0 level (sync input & mask), 1 edge (capture & mask).
- RESET_OUT, 0, reset value of out_port, WIDTH bits.

Ports:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- address  input  3  word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits above WIDTH are ignored.
- readdata  output  32  registered read data; zero-extended above WIDTH.
- in_port  input  WIDTH  asynchronous external inputs.
- out_port  output  WIDTH  output data register.
- irq  output  1  interrupt request, active high.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. All state updates on rising clk.
- Reset values:
  - readdata=0, irq=0, out_port=RESET_OUT;
  - irq_mask=0, edge_capture=0;
  - sync chain and prev register = 0;
  - prime counter = 0.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync_in. prev holds sync_in delayed one cycle.
- Edge detect, per bit:
  - rise = sync_in & ~prev;
  - fall = ~sync_in & prev;
  - the EDGE_TYPE selection is applied to these.
- Prime counter:
  - counts from 0 to SYNC_STAGES+1 after reset, then saturates;
  - edge detection is gated off until it saturates, so inputs already high at reset do not produce a spurious capture.
- Register map (read/write):
  - address 0: read sync_in; write out_port.
  - address 1: read out_port (writes ignored).
  - address 2: read/write irq_mask.
  - address 3: read edge_capture; write 1 to a bit clears that bit, write 0 leaves it.
  - addresses 4–7: read 0, writes ignored (unless the optional feature below is enabled).
- Write occurs when chipselect=1 and write_n=0. Writes take effect on the next clk edge. No wait states.
- Read:
  - readdata is registered every cycle from the address-selected mux, regardless of chipselect;
  - read latency is 1 cycle.
- edge_capture bit update:
  - bit is set when an enabled edge is detected;
  - bit is cleared by a write-1 to address 3;
  - if an edge and a clear hit the same bit in the same cycle, set wins and the bit stays 1.
- irq is registered (one cycle after its source changes):
  - IRQ_TYPE=0: irq = |(sync_in & irq_mask);
  - IRQ_TYPE=1: irq = |(edge_capture & irq_mask).
- Input-to-capture latency: an in_port transition reaches edge_capture SYNC_STAGES+1 cycles later.
- Reset asserted mid-operation: all registers return to reset values on that edge, and the prime counter restarts.

Optional Feature:
- Macro: PIO_BITSET_EN.
- When defined:
  - address 4 write: out_port |= writedata[WIDTH-1:0] (outset);
  - address 5 write: out_port &= ~writedata[WIDTH-1:0] (outclear);
  - both addresses read 0.
- When not defined: addresses 4 and 5 read 0 and writes to them are ignored; there is no extra logic.

Test Plan:
- Reset check, WIDTH=16, RESET_OUT=16'h00A5: after reset, out_port=16'h00A5, readdata=0, irq=0; read address 2 returns 0.
- Out_port write/readback: write 0x1234 to address 0 → out_port=16'h1234 next cycle; read address 1 → readdata=32'h00001234 one cycle after the address is presented.
- Rising-edge capture, EDGE_TYPE=0, IRQ_TYPE=1, mask=16'h0001:
  - raise in_port[0] → edge_capture=0x0001 after 3 cycles, irq=1 one cycle later;
  - write 0x0001 to address 3 → capture and irq clear.
- Spurious-edge suppression and set-wins:
  - hold in_port=16'hFFFF through reset → edge_capture stays 0;
  - a new edge on bit 3 coincident with a write-1 clear of bit 3 → bit 3 reads 1.
- Level IRQ, IRQ_TYPE=0, mask=16'h0080: drive in_port[7]=1 → irq=1 after 3 cycles; drive it to 0 → irq=0 after 3 cycles, with no sticky behaviour.
- PIO_BITSET_EN defined:
  - out_port=16'h00F0, write 0x000F to address 4 → 16'h00FF;
  - write 0x00F0 to address 5 → 16'h000F.
  - Without the macro, the same writes leave out_port unchanged.
